// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the Uart8 receiver: edge-detects rxDone/rxErr, stores {err,byte},
// presents the head first-word-fall-through. A push shows on outValid one cycle later; nothing from rxDone reaches outValid combinationally.
// A push while full with no pop is dropped and counted. Optional UART_RX_FIFO_ERR_DROP_EN discards errored bytes instead of storing them.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2      = 4,
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxDone,
  input  logic                       rxErr,
  input  logic [7:0]                 rxByte,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [7:0]                 outByte,
  output logic                       outErr,
  output logic [DEPTH_LOG2:0]        count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       overflowClr,
  output logic [ERR_COUNT_WIDTH-1:0] errCount,
  output logic [ERR_COUNT_WIDTH-1:0] dropCount
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0]           FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]           ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0]           ONE_PTR  = PTR_W'(1);
  localparam logic [ERR_COUNT_WIDTH-1:0] SAT_MAX  = '1;
  localparam logic [ERR_COUNT_WIDTH-1:0] ONE_STAT = ERR_COUNT_WIDTH'(1);

  // Storage: each entry is {error flag, byte}. Not reset; only entries counted by cnt_q are ever read.
  logic [8:0]       mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [8:0]       head_q;
  logic [8:0]       head_next;
  logic [8:0]       wr_dat;

  logic             rx_done_prev;
  logic             rx_err_prev;
  logic             push;
  logic             push_req;
  logic             err_edge;
  logic             pop;
  logic             wr_en;
  logic             drop;

  logic [ERR_COUNT_WIDTH-1:0] err_cnt_q;
  logic [ERR_COUNT_WIDTH-1:0] drop_cnt_q;
  logic                       overflow_q;

  // Edge detection and push/pop/drop qualification for this cycle.
  always_comb begin
    push     = rxDone & ~rx_done_prev;
    err_edge = rxErr & ~rx_err_prev;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    // Errored bytes never enter the FIFO, so they cannot cause a drop either.
    push_req = push & ~rxErr;
`else
    push_req = push;
`endif
    pop      = outValid & outReady;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    wr_en    = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    wr_dat   = {rxErr, rxByte};
  end

  // Occupancy and next head entry. The head register is loaded either from
  // memory (an older entry moves up) or directly from the incoming byte when
  // the FIFO is, or is about to become, otherwise empty.
  always_comb begin
    rd_ptr_next = rd_ptr + ONE_PTR;
    cnt_next    = cnt_q;
    head_next   = head_q;
    case ({wr_en, pop})
      2'b10:   cnt_next = cnt_q + ONE_CNT;
      2'b01:   cnt_next = cnt_q - ONE_CNT;
      default: cnt_next = cnt_q;
    endcase
    if (pop && (cnt_q > ONE_CNT)) begin
      head_next = mem[rd_ptr_next];
    end else if (wr_en && ((cnt_q == '0) || (pop && (cnt_q == ONE_CNT)))) begin
      head_next = wr_dat;
    end
  end

  // Edge-detect history, updated every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_prev <= 1'b0;
      rx_err_prev  <= 1'b0;
    end else begin
      rx_done_prev <= rxDone;
      rx_err_prev  <= rxErr;
    end
  end

  // Entry write; harmless during reset because occupancy is cleared alongside.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers, occupancy and registered head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
      end
      cnt_q  <= cnt_next;
      head_q <= head_next;
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (overflowClr) begin
        drop_cnt_q <= ONE_STAT;
      end else if (drop_cnt_q != SAT_MAX) begin
        drop_cnt_q <= drop_cnt_q + ONE_STAT;
      end
    end else if (overflowClr) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  // Saturating count of rxErr rising edges, independent of whether a byte is pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_edge && (err_cnt_q != SAT_MAX)) begin
      err_cnt_q <= err_cnt_q + ONE_STAT;
    end
  end

  assign count     = cnt_q;
  assign full      = (cnt_q == FULL_CNT);
  assign outValid  = (cnt_q != '0);
  assign outByte   = head_q[7:0];
  assign overflow  = overflow_q;
  assign errCount  = err_cnt_q;
  assign dropCount = drop_cnt_q;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign outErr = 1'b0;
  // Stored error bit is always 0 in this build; fold it away explicitly.
  logic unused_err_bit;
  assign unused_err_bit = head_q[8];
`else
  assign outErr = head_q[8];
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset state, latency, level-held rxDone,
// fill/overflow/drain, full push+pop, error bytes, reset mid-operation.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;
  logic       outErr;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       overflowClr;
  logic [7:0] errCount;
  logic [7:0] dropCount;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_COUNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .outValid(outValid), .outReady(outReady), .outByte(outByte), .outErr(outErr),
    .count(count), .full(full), .overflow(overflow), .overflowClr(overflowClr),
    .errCount(errCount), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle rxDone pulse followed by one idle cycle.
  task automatic push_byte(input logic [7:0] b, input logic e);
    rxByte = b;
    rxErr  = e;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_b;
    rst = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
    outReady = 1'b0; overflowClr = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_count",    32'(count), 0);
    check("rst_valid",    32'(outValid), 0);
    check("rst_byte",     32'(outByte), 0);
    check("rst_err",      32'(outErr), 0);
    check("rst_full",     32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_errcnt",   32'(errCount), 0);
    check("rst_dropcnt",  32'(dropCount), 0);

    // Single byte, one-cycle latency, then pop
    rxByte = 8'hB5; rxDone = 1'b1;
    tick();
    check("single_valid", 32'(outValid), 1);
    check("single_byte",  32'(outByte), 'hB5);
    check("single_err",   32'(outErr), 0);
    check("single_count", 32'(count), 1);
    rxDone = 1'b0;
    tick();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("pop_count", 32'(count), 0);
    check("pop_valid", 32'(outValid), 0);
    check("empty_hold_byte", 32'(outByte), 'hB5);

    // Level-held rxDone yields exactly one entry
    rxByte = 8'h3C; rxDone = 1'b1;
    repeat (50) tick();
    rxDone = 1'b0;
    tick();
    check("level_count", 32'(count), 1);
    check("level_byte",  32'(outByte), 'h3C);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("level_pop_count", 32'(count), 0);

    // Fill 16, then three drops; the last drop coincides with overflowClr
    for (int i = 0; i < 17; i++) push_byte(8'(i), 1'b0);
    check("fill_count",    32'(count), 16);
    check("fill_full",     32'(full), 1);
    check("fill_overflow", 32'(overflow), 1);
    check("fill_dropcnt",  32'(dropCount), 1);
    check("fill_head",     32'(outByte), 'h00);
    push_byte(8'h11, 1'b0);
    check("drop2_dropcnt", 32'(dropCount), 2);
    rxByte = 8'h12; rxDone = 1'b1; overflowClr = 1'b1;
    tick();
    rxDone = 1'b0; overflowClr = 1'b0;
    tick();
    check("dropclr_overflow", 32'(overflow), 1);
    check("dropclr_dropcnt",  32'(dropCount), 1);
    check("dropclr_count",    32'(count), 16);

    // Streaming drain returns 00..0F in order
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(outValid), 1);
      check("drain_byte",  32'(outByte), 32'(i));
      tick();
    end
    outReady = 1'b0;
    check("drain_count", 32'(count), 0);
    check("drain_valid_end", 32'(outValid), 0);
    overflowClr = 1'b1;
    tick();
    overflowClr = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    check("clr_dropcnt",  32'(dropCount), 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b0);
    check("full2_count", 32'(count), 16);
    rxByte = 8'hAA; rxDone = 1'b1; outReady = 1'b1;
    tick();
    rxDone = 1'b0; outReady = 1'b0;
    check("pushpop_count",    32'(count), 16);
    check("pushpop_overflow", 32'(overflow), 0);
    check("pushpop_dropcnt",  32'(dropCount), 0);
    check("pushpop_head",     32'(outByte), 'h21);
    tick();
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 15) ? 8'hAA : 8'(8'h21 + i);
      check("pushpop_drain", 32'(outByte), 32'(exp_b));
      tick();
    end
    outReady = 1'b0;
    check("pushpop_empty", 32'(count), 0);

    // Errored byte, then a lone rxErr glitch
    push_byte(8'h7E, 1'b1);
    check("errbyte_errcnt", 32'(errCount), 1);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check("errbyte_count", 32'(count), 0);
`else
    check("errbyte_count", 32'(count), 1);
    check("errbyte_byte",  32'(outByte), 'h7E);
    check("errbyte_err",   32'(outErr), 1);
`endif
    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    tick();
    check("glitch_errcnt", 32'(errCount), 2);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check("glitch_count", 32'(count), 0);
`else
    check("glitch_count", 32'(count), 1);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("errbyte_pop", 32'(count), 0);
`endif

    // Reset mid-operation coinciding with an rxDone edge
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b0);
    check("mid_count", 32'(count), 5);
    rxByte = 8'h99; rxDone = 1'b1; rst = 1'b1;
    tick();
    rxDone = 1'b0; rst = 1'b0;
    tick();
    check("midrst_count",   32'(count), 0);
    check("midrst_valid",   32'(outValid), 0);
    check("midrst_errcnt",  32'(errCount), 0);
    check("midrst_dropcnt", 32'(dropCount), 0);
    check("midrst_byte",    32'(outByte), 0);
    push_byte(8'h5A, 1'b0);
    check("after_valid", 32'(outValid), 1);
    check("after_byte",  32'(outByte), 'h5A);
    check("after_count", 32'(count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
